// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the 6-stage core (PC, IF, ID, EX, MEM, WB).
//   Merges per-stage stall requests into one stall vector, converts MEM-stage
//   exceptions into flush + new_pc, runs the debug halt/drain handshake, a stall
//   watchdog and saturating stall/flush event counters.
//
// Ports:
//   clk           in   1      clock, rising edge
//   rst           in   1      asynchronous active-low reset
//   stallreq_if   in   1      instruction bus wait
//   stallreq_id   in   1      ID load-use / branch hazard
//   stallreq_ex   in   1      EX multicycle op
//   stallreq_mem  in   1      data bus wait
//   excepttype    in   32     MEM-stage exception cause, 0 = none
//   cp0_epc       in   32     EPC, target for eret
//   halt_req      in   1      debug halt request (level)
//   stall         out  6      bit i freezes stage i (bit0 = PC .. bit5 = WB)
//   flush         out  1      clear all pipeline registers this cycle
//   new_pc        out  32     redirect target while flush = 1, else 0
//   halt_ack      out  1      pipeline drained and frozen
//   bus_timeout   out  1      one-cycle watchdog pulse
//   stall_cnt     out  CNT_W  cycles with stall != 0, saturating
//   flush_cnt     out  CNT_W  flush cycles, saturating
//
// state  | meaning
// RUN    | normal operation, watchdog active
// DRAIN  | PC/IF frozen, bubbles flow down until ID..WB are empty
// HALTED | whole pipe frozen, halt_ack asserted
module pipe_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned TIMEOUT      = 256,
  parameter int unsigned CNT_W        = 32,
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype,
  input  logic [31:0]      cp0_epc,
  input  logic             halt_req,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             halt_ack,
  output logic             bus_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam int unsigned DC_W = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
  localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [31:0]     EXC_ERET   = 32'h0000000e;

  logic [1:0]      state, state_nx;
  logic [DC_W-1:0] dcnt, dcnt_nx;
  logic [WD_W-1:0] wd_cnt;
  logic [5:0]      merged;
  logic            any_req;
  logic            hazard;
  logic            exc_take;

  // Stall codes are thermometer-shaped, so OR-ing with 6'b000011 gives the
  // max() needed while draining.
  always_comb begin
    merged = 6'b000000;
    if (stallreq_mem)      merged = 6'b011111;
    else if (stallreq_ex)  merged = 6'b001111;
    else if (stallreq_id)  merged = 6'b000111;
    else if (stallreq_if)  merged = 6'b000011;
  end

  assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
  assign hazard  = stallreq_id | stallreq_ex | stallreq_mem;

  // A data-bus wait holds MEM, so the exception is retried once MEM is free.
  assign exc_take = (excepttype != 32'd0) && !stallreq_mem &&
                    ((state == ST_RUN) || (state == ST_DRAIN));

  always_comb begin
    stall  = 6'b000000;
    flush  = 1'b0;
    new_pc = 32'd0;
    if (rst) begin
      if (state == ST_HALTED) begin
        stall = 6'b111111;
      end else if (exc_take) begin
        flush  = 1'b1;
        new_pc = (excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
      end else if (state == ST_DRAIN) begin
        stall = merged | 6'b000011;
      end else begin
        stall = merged;
      end
    end
  end

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    case (state)
      ST_RUN: begin
        if (halt_req && !exc_take) begin
          state_nx = ST_DRAIN;
          dcnt_nx  = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!halt_req) begin
          state_nx = ST_RUN;
        end else if (exc_take) begin
          // flushed instructions restart the drain from scratch
          dcnt_nx = DRAIN_LOAD;
        end else if (!hazard) begin
          if (dcnt == DC_W'(1)) state_nx = ST_HALTED;
          else                  dcnt_nx  = dcnt - DC_W'(1);
        end
      end
      ST_HALTED: begin
        if (!halt_req) state_nx = ST_RUN;
      end
      default: state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      dcnt     <= DRAIN_LOAD;
      halt_ack <= 1'b0;
    end else begin
      state    <= state_nx;
      dcnt     <= dcnt_nx;
      halt_ack <= (state_nx == ST_HALTED);
    end
  end

  // Watchdog: consecutive stalled cycles in RUN; the pulse appears right after
  // the edge that completes the TIMEOUT-th stalled cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt      <= '0;
      bus_timeout <= 1'b0;
    end else begin
      bus_timeout <= 1'b0;
      if ((state != ST_RUN) || !any_req) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WD_LAST) begin
        wd_cnt      <= '0;
        bus_timeout <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((stall != 6'b000000) && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
